// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multicycle fetch/load/store access unit with IR, MDR and byte lanes
// Decodes width/alignment on accept, runs one handshaked memory cycle, reports done/error.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc_valid,
  output logic        acc_ready,
  input  logic        acc_fetch,
  input  logic        acc_write,
  input  logic [31:0] acc_adr,
  input  logic [31:0] acc_wdata,
  input  logic [2:0]  acc_funct3,
  output logic        acc_done,
  output logic        acc_err,
  output logic [1:0]  acc_err_code,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_fetch;
  logic          r_write;
  logic [1:0]    r_lane;
  logic [2:0]    r_funct3;

  logic        w_store;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_illegal;
  logic        w_misaligned;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sx;
  logic [31:0] w_load_ext;

  assign acc_ready = (r_state == S_IDLE);
  assign w_store   = acc_write & ~acc_fetch;

  // Request decode works on the raw inputs so errors are known on the accept edge.
  always_comb begin
    w_is_half = 1'b0;
    w_is_word = 1'b0;
    w_illegal = 1'b0;
    if (acc_fetch) begin
      w_is_word = 1'b1;
    end else begin
      case (acc_funct3)
        3'b000: ;
        3'b001: w_is_half = 1'b1;
        3'b010: w_is_word = 1'b1;
        3'b100, 3'b101: begin
          w_illegal = acc_write;
          w_is_half = acc_funct3[0];
        end
        default: w_illegal = 1'b1;
      endcase
    end
  end

  assign w_misaligned = (w_is_half & acc_adr[0]) | (w_is_word & (acc_adr[1:0] != 2'b00));

  always_comb begin
    w_wmask = 4'b0000;
    w_wdata = 32'h0;
    if (w_store) begin
      case (acc_funct3[1:0])
        2'b00: begin
          w_wmask = 4'b0001 << acc_adr[1:0];
          w_wdata = {4{acc_wdata[7:0]}};
        end
        2'b01: begin
          w_wmask = acc_adr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{acc_wdata[15:0]}};
        end
        default: begin
          w_wmask = 4'b1111;
          w_wdata = acc_wdata;
        end
      endcase
    end
  end

  always_comb begin
    case (r_lane)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_sx   = ~r_funct3[2];
    case (r_funct3[1:0])
      2'b00:   w_load_ext = {{24{w_sx & w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = {{16{w_sx & w_half[15]}}, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_fetch      <= 1'b0;
      r_write      <= 1'b0;
      r_lane       <= 2'b00;
      r_funct3     <= 3'b000;
      ir           <= 32'h0000_0013;
      mdr          <= 32'h0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wmask    <= 4'b0000;
      mem_wdata    <= 32'h0;
      acc_done     <= 1'b0;
      acc_err      <= 1'b0;
      acc_err_code <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (acc_valid) begin
            r_fetch  <= acc_fetch;
            r_write  <= w_store;
            r_lane   <= acc_adr[1:0];
            r_funct3 <= acc_funct3;
            if (w_illegal || w_misaligned) begin
              r_state      <= S_DONE;
              acc_done     <= 1'b1;
              acc_err      <= 1'b1;
              acc_err_code <= w_illegal ? 2'b10 : 2'b01;
            end else begin
              r_state   <= S_ISSUE;
              r_cnt     <= '0;
              mem_en    <= 1'b1;
              mem_we    <= w_store;
              mem_addr  <= {acc_adr[31:2], 2'b00};
              mem_wmask <= w_wmask;
              mem_wdata <= w_wdata;
            end
          end
        end
        S_ISSUE: begin
          // An ack in the final allowed cycle still completes the access.
          if (mem_ack) begin
            if (r_fetch) ir <= mem_rdata;
            else if (!r_write) mdr <= w_load_ext;
            r_state      <= S_DONE;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            acc_done     <= 1'b1;
            acc_err      <= 1'b0;
            acc_err_code <= 2'b00;
          end else if (r_cnt == LAST) begin
            r_state      <= S_DONE;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            acc_done     <= 1'b1;
            acc_err      <= 1'b1;
            acc_err_code <= 2'b11;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          acc_done     <= 1'b0;
          acc_err      <= 1'b0;
          acc_err_code <= 2'b00;
        end
      endcase
    end
  end

endmodule
